// File: rtl/branch_cmp_arbiter.sv
// Round-robin arbiter sharing one branch comparator between two requesters.
// Optional BRANCH_STATS_EN builds saturating taken/not-taken/illegal counters.
module branch_cmp_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic [2:0]        req0_func,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    input  logic [2:0]        req1_func,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [XLEN-1:0]   cmp_a,
    output logic [XLEN-1:0]   cmp_b,
    output logic [2:0]        cmp_func,
    input  logic              cmp_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_taken,
    output logic              rsp_illegal,
    output logic              rsp_src,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_ntaken,
    output logic [STAT_W-1:0] stat_illegal
);

    typedef enum logic [1:0] {StIdle, StEval, StHold} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q;
    logic [XLEN-1:0]    cmp_a_q, cmp_b_q;
    logic [2:0]         cmp_func_q;
    logic [TAG_W-1:0]   tag_q;
    logic               src_q, illegal_q, taken_q, valid_q;
    logic               any_valid, grant_sel, grant, rsp_fire;
    logic [2:0]         sel_func;

    always_comb begin
        any_valid  = req0_valid | req1_valid;
        // Both pending: alternate away from the last winner; otherwise take whoever asks.
        grant_sel  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        grant      = (state_q == StIdle) & any_valid;
        req0_ready = grant & ~grant_sel;
        req1_ready = grant & grant_sel;
        sel_func   = grant_sel ? req1_func : req0_func;
        rsp_fire   = valid_q & rsp_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_valid) state_d = StEval;
            StEval:  state_d = StHold;
            StHold:  if (rsp_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            cmp_func_q   <= '0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            illegal_q    <= 1'b0;
            taken_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                cmp_a_q      <= grant_sel ? req1_a : req0_a;
                cmp_b_q      <= grant_sel ? req1_b : req0_b;
                cmp_func_q   <= sel_func;
                tag_q        <= grant_sel ? req1_tag : req0_tag;
                src_q        <= grant_sel;
                illegal_q    <= (sel_func[2:1] == 2'b01);
                last_grant_q <= grant_sel;
            end
            if (state_q == StEval) begin
                taken_q <= cmp_result & ~illegal_q;
                valid_q <= 1'b1;
            end else if (rsp_fire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign cmp_func    = cmp_func_q;
    assign rsp_valid   = valid_q;
    assign rsp_taken   = taken_q;
    assign rsp_illegal = illegal_q;
    assign rsp_src     = src_q;
    assign rsp_tag     = tag_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] cnt_taken_q, cnt_ntaken_q, cnt_illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_taken_q   <= '0;
            cnt_ntaken_q  <= '0;
            cnt_illegal_q <= '0;
        end else if (rsp_fire) begin
            if (illegal_q) begin
                if (cnt_illegal_q != '1) cnt_illegal_q <= cnt_illegal_q + STAT_W'(1);
            end else if (taken_q) begin
                if (cnt_taken_q != '1) cnt_taken_q <= cnt_taken_q + STAT_W'(1);
            end else begin
                if (cnt_ntaken_q != '1) cnt_ntaken_q <= cnt_ntaken_q + STAT_W'(1);
            end
        end
    end

    assign stat_taken   = cnt_taken_q;
    assign stat_ntaken  = cnt_ntaken_q;
    assign stat_illegal = cnt_illegal_q;
`else
    assign stat_taken   = '0;
    assign stat_ntaken  = '0;
    assign stat_illegal = '0;
`endif

endmodule
